// File: rtl/gen_fip_sign_vec_width_conv_seq_if.sv
// Bus bundle for the signed fixed-point vector width converter.
// The initiator drives start and the packed vector; the converter answers.
interface gen_fip_sign_vec_width_conv_seq_if #(
    parameter int IN_NUM_W  = 17,
    parameter int OUT_NUM_W = 14,
    parameter int VEC_LEN   = 8,
    parameter int IDX_W     = $clog2(VEC_LEN)
);
    logic                         i_start_pls;
    logic [VEC_LEN*IN_NUM_W-1:0]  i_vec;
    logic                         o_busy;
    logic                         o_done_pls;
    logic [VEC_LEN*OUT_NUM_W-1:0] o_vec;
    logic [VEC_LEN-1:0]           o_sat_flags;
    logic [IDX_W:0]               o_sat_cnt;

    modport master (
        output i_start_pls,
        output i_vec,
        input  o_busy,
        input  o_done_pls,
        input  o_vec,
        input  o_sat_flags,
        input  o_sat_cnt
    );

    modport slave (
        input  i_start_pls,
        input  i_vec,
        output o_busy,
        output o_done_pls,
        output o_vec,
        output o_sat_flags,
        output o_sat_cnt
    );
endinterface

// File: rtl/gen_fip_sign_vec_width_conv_seq.sv
// Sequential signed fixed-point vector width converter.
// One element per cycle, round half toward +inf, saturating.
module gen_fip_sign_vec_width_conv_seq #(
    parameter  int IN_NUM_INT_W    = 6,
    parameter  int IN_NUM_FRACT_W  = 11,
    parameter  int OUT_NUM_INT_W   = 4,
    parameter  int OUT_NUM_FRACT_W = 10,
    parameter  int VEC_LEN         = 8,
    localparam int IN_NUM_W        = IN_NUM_INT_W + IN_NUM_FRACT_W,
    localparam int OUT_NUM_W       = OUT_NUM_INT_W + OUT_NUM_FRACT_W,
    localparam int IDX_W           = $clog2(VEC_LEN)
) (
    input logic clk,
    input logic rst,
    gen_fip_sign_vec_width_conv_seq_if.slave bus
);

    localparam int D     = IN_NUM_FRACT_W - OUT_NUM_FRACT_W;
    localparam int WIDEN = (D < 0) ? -D : 0;
    localparam int MAXW  = (IN_NUM_W > OUT_NUM_W) ? IN_NUM_W : OUT_NUM_W;
    localparam int WW    = MAXW + WIDEN + 2;
    localparam int CW    = IDX_W + 1;
    localparam int IV_W  = VEC_LEN * IN_NUM_W;
    localparam int OV_W  = VEC_LEN * OUT_NUM_W;

    localparam logic signed [WW-1:0] MAXV =
        {{(WW-OUT_NUM_W+1){1'b0}}, {(OUT_NUM_W-1){1'b1}}};
    localparam logic signed [WW-1:0] MINV =
        {{(WW-OUT_NUM_W+1){1'b1}}, {(OUT_NUM_W-1){1'b0}}};
    localparam logic [IDX_W-1:0] LAST = IDX_W'(VEC_LEN - 1);

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        DONE
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [IV_W-1:0]    cap_q, cap_d;
    logic [OV_W-1:0]    work_q, work_d;
    logic [VEC_LEN-1:0] flg_q, flg_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [OV_W-1:0]    ovec_q, ovec_d;
    logic [VEC_LEN-1:0] osat_q, osat_d;
    logic [CW-1:0]      ocnt_q, ocnt_d;

    logic [IN_NUM_W-1:0]  cur;
    logic signed [WW-1:0] ext;
    logic signed [WW-1:0] scaled;
    logic [OUT_NUM_W-1:0] elem_res;
    logic                 elem_sat;

    assign cur = cap_q[int'(idx_q)*IN_NUM_W +: IN_NUM_W];
    assign ext = {{(WW-IN_NUM_W){cur[IN_NUM_W-1]}}, cur};

    // Align the binary point; narrowing adds the first dropped bit.
    generate
        if (D > 0) begin : g_narrow
            logic signed [WW-1:0] shr;
            assign shr    = ext >>> D;
            assign scaled = shr + $signed({{(WW-1){1'b0}}, cur[D-1]});
        end else if (D < 0) begin : g_widen
            assign scaled = ext <<< WIDEN;
        end else begin : g_same
            assign scaled = ext;
        end
    endgenerate

    // Clamp the aligned value into the output range.
    always_comb begin
        elem_sat = 1'b0;
        elem_res = scaled[OUT_NUM_W-1:0];
        if (scaled > MAXV) begin
            elem_sat = 1'b1;
            elem_res = MAXV[OUT_NUM_W-1:0];
        end else if (scaled < MINV) begin
            elem_sat = 1'b1;
            elem_res = MINV[OUT_NUM_W-1:0];
        end
    end

    // Next-state and datapath updates for IDLE/CONV/DONE.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cap_d   = cap_q;
        work_d  = work_q;
        flg_d   = flg_q;
        cnt_d   = cnt_q;
        ovec_d  = ovec_q;
        osat_d  = osat_q;
        ocnt_d  = ocnt_q;
        unique case (state_q)
            IDLE: begin
                if (bus.i_start_pls) begin
                    cap_d   = bus.i_vec;
                    work_d  = '0;
                    flg_d   = '0;
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = CONV;
                end
            end
            CONV: begin
                work_d[int'(idx_q)*OUT_NUM_W +: OUT_NUM_W] = elem_res;
                flg_d[idx_q] = elem_sat;
                if (elem_sat) begin
                    cnt_d = cnt_q + CW'(1);
                end
                if (idx_q == LAST) begin
                    // Publish on entry to DONE so outputs ride with the pulse.
                    idx_d   = '0;
                    ovec_d  = work_d;
                    osat_d  = flg_d;
                    ocnt_d  = cnt_d;
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    // State and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            cap_q   <= '0;
            work_q  <= '0;
            flg_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ovec_q  <= '0;
            osat_q  <= '0;
            ocnt_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cap_q   <= cap_d;
            work_q  <= work_d;
            flg_q   <= flg_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            ovec_q  <= ovec_d;
            osat_q  <= osat_d;
            ocnt_q  <= ocnt_d;
        end
    end

    assign bus.o_busy      = busy_q;
    assign bus.o_done_pls  = done_q;
    assign bus.o_vec       = ovec_q;
    assign bus.o_sat_flags = osat_q;
    assign bus.o_sat_cnt   = ocnt_q;

endmodule
